// File: rtl/ps_bridge_pkg.sv
// Shared types and helpers for the AXI-Lite to ps_if bridge.
package ps_bridge_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} r_state_t;

  // Byte address is in range when nothing above the word-address field is set.
  function automatic logic in_range(input logic [63:0] addr, input int ps_aw);
    return (addr >> (ps_aw + 2)) == 64'd0;
  endfunction
endpackage

// File: rtl/ps_if.sv
// Register-file access port: one write channel (w/b) and one read channel (ar/r).
interface ps_if #(parameter int ADDR_WIDTH = 4);
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [31:0]           wdata, rdata;
  logic                  wvalid, wready, bvalid;
  logic                  arvalid, aready, rvalid;

  modport master(output waddr, wdata, wvalid, raddr, arvalid,
                 input  wready, bvalid, aready, rvalid, rdata);
  modport slave (input  waddr, wdata, wvalid, raddr, arvalid,
                 output wready, bvalid, aready, rvalid, rdata);
endinterface

// File: rtl/ps_timeout_ctr.sv
// Wait counter: cleared outside the waiting state, flags expiry on the last counted cycle.
module ps_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/axil_ps_bridge.sv
// AXI4-Lite slave to ps_if master; independent write and read FSMs, one outstanding each.
module axil_ps_bridge
  import ps_bridge_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [31:0]               s_axil_wdata,
  input  logic [3:0]                s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [31:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  ps_if.master                      ps_o
);
  localparam int PS_ADDR_WIDTH = $bits(ps_o.waddr);

  w_state_t w_state, w_nxt;
  r_state_t r_state, r_nxt;
  logic live;
  logic aw_held, w_held, aw_ok_q, strb_ok_q;
  logic aw_hs, w_hs, aw_ok_c, strb_ok_c, b_set, b_err, w_expired;
  logic [PS_ADDR_WIDTH-1:0] waddr_q, raddr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [1:0]  bresp_q, rresp_q;
  logic r_set, r_err, r_expired, rd_done;

  // Readies stay low through reset and the first cycle after it.
  assign s_axil_awready = live && (w_state == W_IDLE) && !aw_held;
  assign s_axil_wready  = live && (w_state == W_IDLE) && !w_held;
  assign s_axil_bvalid  = (w_state == W_RESP);
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = live && (r_state == R_IDLE);
  assign s_axil_rvalid  = (r_state == R_RESP);
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

  assign ps_o.wvalid  = (w_state == W_ISSUE);
  assign ps_o.waddr   = waddr_q;
  assign ps_o.wdata   = wdata_q;
  assign ps_o.arvalid = (r_state == R_ISSUE);
  assign ps_o.raddr   = raddr_q;

  assign aw_hs     = s_axil_awvalid && s_axil_awready;
  assign w_hs      = s_axil_wvalid && s_axil_wready;
  assign aw_ok_c   = aw_held ? aw_ok_q : in_range(64'(s_axil_awaddr), PS_ADDR_WIDTH);
  assign strb_ok_c = w_held ? strb_ok_q : (s_axil_wstrb == 4'hF);
  assign rd_done   = ps_o.aready && ps_o.rvalid;

  ps_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_w_to (
    .clk(clk), .rst_n(rst_n), .clr(w_state != W_WAIT),
    .en((w_state == W_WAIT) && !ps_o.bvalid), .expired(w_expired));

  ps_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_r_to (
    .clk(clk), .rst_n(rst_n), .clr(r_state != R_ISSUE),
    .en((r_state == R_ISSUE) && !rd_done), .expired(r_expired));

  always_comb begin
    w_nxt = w_state;
    b_set = 1'b0;
    b_err = 1'b0;
    case (w_state)
      W_IDLE:
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          if (aw_ok_c && strb_ok_c) w_nxt = W_ISSUE;
          else begin w_nxt = W_RESP; b_set = 1'b1; b_err = 1'b1; end
        end
      W_ISSUE: if (ps_o.wready) w_nxt = W_WAIT;
      W_WAIT:
        if (ps_o.bvalid) begin w_nxt = W_RESP; b_set = 1'b1; end
        else if (w_expired) begin w_nxt = W_RESP; b_set = 1'b1; b_err = 1'b1; end
      W_RESP:  if (s_axil_bready) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_nxt = r_state;
    r_set = 1'b0;
    r_err = 1'b0;
    case (r_state)
      R_IDLE:
        if (s_axil_arvalid && s_axil_arready) begin
          if (in_range(64'(s_axil_araddr), PS_ADDR_WIDTH)) r_nxt = R_ISSUE;
          else begin r_nxt = R_RESP; r_set = 1'b1; r_err = 1'b1; end
        end
      R_ISSUE:
        if (rd_done) begin r_nxt = R_RESP; r_set = 1'b1; end
        else if (r_expired) begin r_nxt = R_RESP; r_set = 1'b1; r_err = 1'b1; end
      R_RESP:  if (s_axil_rready) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_ok_q   <= 1'b0;
      strb_ok_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      live    <= 1'b1;
      w_state <= w_nxt;
      r_state <= r_nxt;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_ok_q <= aw_ok_c;
        waddr_q <= s_axil_awaddr[PS_ADDR_WIDTH+1:2];
      end
      if (w_hs) begin
        w_held    <= 1'b1;
        strb_ok_q <= strb_ok_c;
        wdata_q   <= s_axil_wdata;
      end
      // Capture flags double as the one-outstanding-write interlock.
      if (w_state == W_RESP && s_axil_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (b_set) bresp_q <= b_err ? RESP_SLVERR : RESP_OKAY;
      if (s_axil_arvalid && s_axil_arready) raddr_q <= s_axil_araddr[PS_ADDR_WIDTH+1:2];
      if (r_set) begin
        rresp_q <= r_err ? RESP_SLVERR : RESP_OKAY;
        rdata_q <= r_err ? 32'd0 : ps_o.rdata;
      end
    end
  end
endmodule

// File: tb/tb_axil_ps_bridge.sv
// Scoreboard bench for axil_ps_bridge against a 16-word register-file node model.
module tb_axil_ps_bridge;
  import ps_bridge_pkg::*;

  typedef struct { logic [1:0] resp; logic [31:0] data; } rexp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_arvalid = 1'b0;
  logic s_axil_bready = 1'b1, s_axil_rready = 1'b1;
  logic s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata;

  ps_if #(.ADDR_WIDTH(4)) ps ();

  axil_ps_bridge #(.AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .ps_o(ps));

  // Register-file node: wready gated by the bench, bvalid one cycle after accept.
  logic [31:0] mem [16];
  logic [31:0] sh [16];
  logic mem_ok = 1'b0, bpend = 1'b0, wready_en = 1'b1, b_dis = 1'b0;
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
      mem_ok <= 1'b1;
    end else if (ps.wvalid && ps.wready) mem[ps.waddr] <= ps.wdata;
    bpend <= rst_n && ps.wvalid && ps.wready;
  end
  assign ps.wready = wready_en;
  assign ps.bvalid = bpend && !b_dis;
  assign ps.aready = 1'b1;
  assign ps.rvalid = ps.arvalid;
  assign ps.rdata  = mem[ps.raddr];

  int total = 0, bad = 0, cyc = 0;
  int ps_w_cnt = 0, ps_w_cyc = 0, b_cnt = 0, b_cyc = 0, r_cyc = 0;
  logic [3:0]  ps_waddr;
  logic [31:0] ps_wdata;
  logic [1:0]  b_e;
  rexp_t r_e;
  logic [1:0] bq [$];
  rexp_t rq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (ps.wvalid && ps.wready) begin
      ps_w_cnt++; ps_w_cyc = cyc; ps_waddr = ps.waddr; ps_wdata = ps.wdata;
    end
    if (s_axil_bvalid && s_axil_bready) begin
      b_cnt++; b_cyc = cyc;
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else begin b_e = bq.pop_front(); chk("bresp", 64'(s_axil_bresp), 64'(b_e)); end
    end
    if (s_axil_rvalid && s_axil_rready) begin
      r_cyc = cyc;
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        r_e = rq.pop_front();
        chk("rresp", 64'(s_axil_rresp), 64'(r_e.resp));
        chk("rdata", 64'(s_axil_rdata), 64'(r_e.data));
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input logic [1:0] exp, output int c0);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int n = 0;
    bq.push_back(exp);
    c0 = cyc;
    s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      if (n == lead) begin s_axil_awaddr = addr; s_axil_awvalid = 1'b1; end
      @(negedge clk);
      aw_f = s_axil_awvalid && s_axil_awready;
      w_f  = s_axil_wvalid && s_axil_wready;
      @(posedge clk); #1;
      if (aw_f) begin s_axil_awvalid = 1'b0; aw_done = 1; end
      if (w_f)  begin s_axil_wvalid = 1'b0; w_done = 1; end
      n++;
    end
    if (!(aw_done && w_done)) chk("wr_handshake_timeout", 0, 1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [1:0] er, input logic [31:0] ed,
                          output int c0);
    rexp_t e;
    bit f = 0;
    int n = 0;
    e.resp = er; e.data = ed;
    rq.push_back(e);
    c0 = cyc;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    while (!f && n < 50) begin
      @(negedge clk);
      f = s_axil_arvalid && s_axil_arready;
      @(posedge clk); #1;
      n++;
    end
    s_axil_arvalid = 1'b0;
    if (!f) chk("rd_handshake_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      chk("drain_timeout", 0, 1);
      bq.delete(); rq.delete();
    end
  endtask

  initial begin
    int c0, rc0, p0, n;
    for (int i = 0; i < 16; i++) sh[i] = 32'h1000_0000 + i;
    #12;
    chk("rst_axi", {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid,
                    s_axil_bresp, s_axil_rresp, s_axil_rdata}, 0);
    chk("rst_ps", {ps.wvalid, ps.arvalid, ps.waddr, ps.wdata, ps.raddr}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous AW+W, then read-back
    p0 = ps_w_cnt;
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, RESP_OKAY, c0);
    sh[1] = 32'hDEADBEEF;
    drain();
    chk("ps_w_lat", ps_w_cyc - c0, 1);
    chk("ps_waddr", ps_waddr, 1);
    chk("ps_wdata", ps_wdata, 32'hDEADBEEF);
    chk("b_lat", b_cyc - c0, 3);
    chk("ps_w_pulses", ps_w_cnt - p0, 1);
    axi_read(32'h04, RESP_OKAY, sh[1], rc0);
    drain();
    chk("r_lat", r_cyc - rc0, 2);

    // W three cycles ahead of AW; readies held low while B stalls
    s_axil_bready = 1'b0;
    p0 = ps_w_cnt;
    axi_write(32'h08, 32'h12345678, 4'hF, 3, RESP_OKAY, c0);
    sh[2] = 32'h12345678;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rdy_hold", {s_axil_awready, s_axil_wready}, 0);
    end
    chk("b_pending", s_axil_bvalid, 1);
    @(posedge clk); #1 s_axil_bready = 1'b1;
    drain();
    @(negedge clk);
    chk("rdy_back", {s_axil_awready, s_axil_wready}, 2'b11);
    @(posedge clk); #1;
    chk("lead_pulses", ps_w_cnt - p0, 1);
    chk("lead_waddr", ps_waddr, 2);
    axi_read(32'h08, RESP_OKAY, sh[2], rc0);
    drain();

    // Out of range write and read
    p0 = ps_w_cnt;
    axi_write(32'h1000, 32'hCAFEF00D, 4'hF, 0, RESP_SLVERR, c0);
    drain();
    chk("oor_pulses", ps_w_cnt - p0, 0);
    axi_read(32'h1000, RESP_SLVERR, 32'h0, rc0);
    drain();

    // Partial strobe is rejected and leaves the register alone
    p0 = ps_w_cnt;
    axi_write(32'h04, 32'h00000055, 4'h3, 0, RESP_SLVERR, c0);
    drain();
    chk("strb_pulses", ps_w_cnt - p0, 0);
    axi_read(32'h04, RESP_OKAY, sh[1], rc0);
    drain();

    // Node never answers: timeout, then normal recovery
    b_dis = 1'b1;
    axi_write(32'h0C, 32'hA5A5A5A5, 4'hF, 0, RESP_SLVERR, c0);
    sh[3] = 32'hA5A5A5A5;
    drain();
    b_dis = 1'b0;
    chk("to_lat", b_cyc - (ps_w_cyc + 1), 16);
    axi_write(32'h0C, 32'h00000011, 4'hF, 0, RESP_OKAY, c0);
    sh[3] = 32'h11;
    drain();
    axi_read(32'h0C, RESP_OKAY, sh[3], rc0);
    drain();

    // B stalled ten cycles while a read completes
    s_axil_bready = 1'b0;
    axi_write(32'h14, 32'h00000077, 4'hF, 0, RESP_OKAY, c0);
    sh[5] = 32'h77;
    n = 0;
    while (!s_axil_bvalid && n < 20) begin @(negedge clk); n++; end
    chk("b_seen", s_axil_bvalid, 1);
    @(posedge clk); #1;
    axi_read(32'h00, RESP_OKAY, sh[0], rc0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("b_stall", {s_axil_bvalid, s_axil_bresp}, {1'b1, RESP_OKAY});
    end
    chk("r_lat_stall", r_cyc - rc0, 2);
    chk("r_done_stall", rq.size(), 0);
    @(posedge clk); #1 s_axil_bready = 1'b1;
    drain();

    // Reset in W_ISSUE drops everything
    wready_en = 1'b0;
    p0 = ps_w_cnt;
    axi_write(32'h18, 32'h00000099, 4'hF, 0, RESP_OKAY, c0);
    n = 0;
    do begin @(negedge clk); n++; end while (!ps.wvalid && n < 10);
    chk("issue_seen", ps.wvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_valids", {ps.wvalid, ps.arvalid, s_axil_bvalid, s_axil_rvalid,
                       s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    bq.delete();
    n = b_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wready_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_b_after_rst", b_cnt - n, 0);
    chk("no_ps_w_after_rst", ps_w_cnt - p0, 0);
    axi_read(32'h18, RESP_OKAY, sh[6], rc0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
